// File: rtl/risc16_ctrl_if.sv
// risc16_ctrl_if: memory bus between the RiSC-16 control FSM (master) and memory/datapath (slave)
//   mem_req/mem_we/mem_addr_sel: request, write qualifier, address select (0=PC, 1=alu_out)
//   mem_ready/mem_rdata: completion strobe and read data; mdr: latched LW data for rf_wsel=01
interface risc16_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] mdr;
  modport master (output mem_req, mem_we, mem_addr_sel, mdr, input mem_ready, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr_sel, mdr, output mem_ready, mem_rdata);
endinterface

// File: rtl/risc16_ctrl_fsm.sv
// risc16_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the RiSC-16 core
//   in:  clk, rst (sync, active-high), instr (IR), eq (ALU EQ), bus (memory master)
//   out: ir_we, rf_raddr1/2, rf_we, rf_waddr, rf_wsel, pc_we, pc_sel,
//        MUX_alu1, MUX_alu2, FUNC_alu, halted, fault, instr_count
module risc16_ctrl_fsm #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             eq,
  risc16_ctrl_if.master    bus,
  output logic             ir_we,
  output logic [2:0]       rf_raddr1,
  output logic [2:0]       rf_raddr2,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic [1:0]       rf_wsel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             MUX_alu1,
  output logic             MUX_alu2,
  output logic [1:0]       FUNC_alu,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [2:0] OP_ADD = 3'd0, OP_ADDI = 3'd1, OP_NAND = 3'd2, OP_LUI = 3'd3;
  localparam logic [2:0] OP_SW = 3'd4, OP_LW = 3'd5, OP_BEQ = 3'd6, OP_JALR = 3'd7;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT} state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             taken_q, taken_d;
  logic [15:0]      mdr_q, mdr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op, ra, rb, rc;
  logic             timeout;
  assign op = instr[15:13];
  assign ra = instr[12:10];
  assign rb = instr[9:7];
  assign rc = instr[2:0];
  // Once the counter has reached the limit the request faults even if memory answers now.
  assign timeout     = wait_q == WW'(MAX_WAIT);
  assign rf_raddr1   = op == OP_BEQ ? ra : rb;
  assign rf_raddr2   = (op == OP_ADD || op == OP_NAND) ? rc : op == OP_SW ? ra : rb;
  assign rf_waddr    = ra;
  assign rf_wsel     = op == OP_LW ? 2'b01 : op == OP_JALR ? 2'b10 : 2'b00;
  assign pc_sel      = (op == OP_BEQ && taken_q) ? 2'b01 : op == OP_JALR ? 2'b10 : 2'b00;
  assign MUX_alu1    = op == OP_LUI;
  assign MUX_alu2    = op == OP_ADDI || op == OP_LW || op == OP_SW;
  assign FUNC_alu    = op == OP_NAND ? 2'b01 : (op == OP_LUI || op == OP_JALR) ? 2'b10 :
                       op == OP_BEQ ? 2'b11 : 2'b00;
  assign halted      = state_q == HALT;
  assign fault       = state_q == FAULT;
  assign instr_count = cnt_q;
  assign bus.mdr     = mdr_q;
  always_comb begin
    state_d          = state_q;
    taken_d          = taken_q;
    mdr_d            = mdr_q;
    cnt_d            = cnt_q;
    ir_we            = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    rf_we            = 1'b0;
    pc_we            = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_req = 1'b1;
        ir_we       = bus.mem_ready && !timeout;
        state_d     = timeout ? FAULT : bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        taken_d = eq;
        state_d = (op == OP_JALR && instr[6:0] != 7'd0) ? HALT :
                  (op == OP_LW || op == OP_SW) ? MEM : WB;
      end
      MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = op == OP_SW;
        mdr_d            = (bus.mem_ready && !timeout && op == OP_LW) ? bus.mem_rdata : mdr_q;
        state_d          = timeout ? FAULT : bus.mem_ready ? WB : MEM;
      end
      WB: begin
        pc_we   = 1'b1;
        rf_we   = op != OP_SW && op != OP_BEQ && ra != 3'd0;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = FETCH;
      end
      default: ;
    endcase
    wait_d = (bus.mem_req && !bus.mem_ready && state_d == state_q) ? wait_q + WW'(1) : '0;
    // Nothing may be written while reset is held, whatever state it caught us in.
    if (rst) begin
      ir_we       = 1'b0;
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      rf_we       = 1'b0;
      pc_we       = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      wait_q  <= '0;
      taken_q <= 1'b0;
      mdr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      taken_q <= taken_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// tb_risc16_ctrl_fsm: randomized instruction-level check of risc16_ctrl_fsm against an ISA-table model
module tb_risc16_ctrl_fsm;
  localparam int MAX_WAIT = 15;
  // Per-opcode properties, bit/field index = opcode (ADD,ADDI,NAND,LUI,SW,LW,BEQ,JALR)
  localparam logic [7:0]  M1_T = 8'b0000_1000;
  localparam logic [7:0]  M2_T = 8'b0011_0010;
  localparam logic [7:0]  WR_T = 8'b1010_1111;
  localparam logic [15:0] FN_T = {2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0;
  logic        eq = 1'b0;
  logic        ir_we, rf_we, pc_we, MUX_alu1, MUX_alu2, halted, fault;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [1:0]  rf_wsel, pc_sel, FUNC_alu;
  logic [15:0] instr_count;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_cnt = 16'h0;
  bit          stop;
  bit          ok;
  logic [15:0] d_ins [14] = '{16'h0503, 16'hA505, 16'h8505, 16'hC57E, 16'hC57E, 16'h67FF, 16'h0082,
                              16'hE480, 16'h2485, 16'hA505, 16'hE001, 16'h0503, 16'hA505, 16'h8505};
  int          d_lf [14] = '{0, 0, 1, 0, 0, 0, 0, 0, 14, 0, 0, 15, 0, 2};
  int          d_lm [14] = '{0, 3, 2, 0, 0, 0, 0, 0, 0, 14, 0, 0, 15, 20};
  bit          d_eq [14] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  risc16_ctrl_if bus();

  risc16_ctrl_fsm #(.MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .eq(eq), .bus(bus),
    .ir_we(ir_we), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .pc_we(pc_we), .pc_sel(pc_sel),
    .MUX_alu1(MUX_alu1), .MUX_alu2(MUX_alu2), .FUNC_alu(FUNC_alu),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag);
    check({tag, "_pc_we"}, 16'(pc_we), 16'd0);
    check({tag, "_rf_we"}, 16'(rf_we), 16'd0);
    check({tag, "_ir_we"}, 16'(ir_we), 16'd0);
    check({tag, "_mem_req"}, 16'(bus.mem_req), 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    tick();
    @(negedge clk);
    quiet("rst");
    tick();
    rst = 1'b0;
    exp_cnt = 16'h0;
    #1;
    check("rst_req", 16'(bus.mem_req), 16'd1);
    check("rst_sel", 16'(bus.mem_addr_sel), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_fault", 16'(fault), 16'd0);
    check("rst_cnt", instr_count, 16'd0);
  endtask

  task automatic mem_phase(input bit fetch, input int lat, input logic [15:0] rd, input bit we,
                           output bit done);
    done = 1'b0;
    for (int k = 0; k <= MAX_WAIT && !done; k++) begin
      bus.mem_ready = (k == lat);
      bus.mem_rdata = rd;
      @(negedge clk);
      check(fetch ? "f_req" : "m_req", 16'(bus.mem_req), 16'd1);
      check(fetch ? "f_sel" : "m_sel", 16'(bus.mem_addr_sel), 16'(!fetch));
      check(fetch ? "f_we" : "m_we", 16'(bus.mem_we), 16'(we));
      check(fetch ? "f_ir_we" : "m_ir_we", 16'(ir_we), 16'(fetch && k == lat && k < MAX_WAIT));
      check(fetch ? "f_pc_we" : "m_pc_we", 16'(pc_we), 16'd0);
      tick();
      done = k == lat && k < MAX_WAIT;
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic sticky_tail(input bit is_halt);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("st_halted", 16'(halted), 16'(is_halt));
      check("st_fault", 16'(fault), 16'(!is_halt));
      check("st_cnt", instr_count, exp_cnt);
      quiet("st");
      tick();
    end
  endtask

  task automatic run(input logic [15:0] ins, input int lf, input int lm, input bit eqv,
                     output bit halt_or_fault);
    logic [2:0]  op, ra, rb, rc, r1, r2;
    logic [1:0]  ws, ps;
    logic [15:0] rdat;
    bit          wr, hlt, mem, done;
    op   = ins[15:13];
    ra   = ins[12:10];
    rb   = ins[9:7];
    rc   = ins[2:0];
    r1   = op == 3'd6 ? ra : rb;
    r2   = (op == 3'd0 || op == 3'd2) ? rc : op == 3'd4 ? ra : rb;
    ws   = op == 3'd5 ? 2'b01 : op == 3'd7 ? 2'b10 : 2'b00;
    ps   = (op == 3'd6 && eqv) ? 2'b01 : op == 3'd7 ? 2'b10 : 2'b00;
    wr   = WR_T[op] && ra != 3'd0;
    hlt  = op == 3'd7 && ins[6:0] != 7'd0;
    mem  = op == 3'd4 || op == 3'd5;
    rdat = 16'($urandom);
    halt_or_fault = 1'b1;
    mem_phase(1'b1, lf, ins, 1'b0, done);
    if (!done) begin
      sticky_tail(1'b0);
      return;
    end
    instr = ins;
    @(negedge clk);
    check("d_raddr1", 16'(rf_raddr1), 16'(r1));
    check("d_raddr2", 16'(rf_raddr2), 16'(r2));
    check("d_cnt", instr_count, exp_cnt);
    quiet("d");
    tick();
    eq = eqv;
    @(negedge clk);
    check("e_mux1", 16'(MUX_alu1), 16'(M1_T[op]));
    if (op != 3'd3 && op != 3'd7) check("e_mux2", 16'(MUX_alu2), 16'(M2_T[op]));
    check("e_func", 16'(FUNC_alu), 16'(FN_T[int'(op) * 2 +: 2]));
    quiet("e");
    tick();
    eq = 1'($urandom);
    if (hlt) begin
      sticky_tail(1'b1);
      return;
    end
    if (mem) begin
      mem_phase(1'b0, lm, rdat, op == 3'd4, done);
      if (!done) begin
        sticky_tail(1'b0);
        return;
      end
    end
    @(negedge clk);
    check("wb_pc_we", 16'(pc_we), 16'd1);
    check("wb_pc_sel", 16'(pc_sel), 16'(ps));
    check("wb_rf_we", 16'(rf_we), 16'(wr));
    check("wb_waddr", 16'(rf_waddr), 16'(ra));
    check("wb_wsel", 16'(rf_wsel), 16'(ws));
    check("wb_raddr1", 16'(rf_raddr1), 16'(r1));
    check("wb_raddr2", 16'(rf_raddr2), 16'(r2));
    check("wb_req", 16'(bus.mem_req), 16'd0);
    if (op == 3'd5) check("wb_mdr", bus.mdr, rdat);
    tick();
    exp_cnt++;
    halt_or_fault = 1'b0;
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      run(d_ins[i], d_lf[i], d_lm[i], d_eq[i], stop);
      if (stop) do_reset();
    end
    mem_phase(1'b1, 0, 16'hA505, 1'b0, ok);
    instr = 16'hA505;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("mr_req", 16'(bus.mem_req), 16'd1);
    check("mr_sel", 16'(bus.mem_addr_sel), 16'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    quiet("mr_rst");
    tick();
    rst = 1'b0;
    exp_cnt = 16'h0;
    #1;
    check("mr_fetch_req", 16'(bus.mem_req), 16'd1);
    check("mr_fetch_sel", 16'(bus.mem_addr_sel), 16'd0);
    check("mr_cnt", instr_count, 16'd0);
    for (int i = 0; i < 400; i++) begin
      int a, b;
      a = $urandom_range(0, 19);
      b = $urandom_range(0, 19);
      run(16'($urandom), a < 16 ? a % 4 : a - 4, b < 16 ? b % 4 : b - 4, 1'($urandom), stop);
      if (stop) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
